// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and result signals between decode, the sequencer and the execute-stage ALU.
// The slave modport is the sequencer's view; master is the surrounding pipeline and ALU.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_W = 40
);
  localparam int unsigned OP_W   = 5;
  localparam int unsigned SDIR_W = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned FLAG_W = 4;

  // request side
  logic              controlInSeqValid;
  logic              controlOutSeqReady;
  logic [OP_W-1:0]   controlInSeqOp;
  logic [SDIR_W-1:0] controlInSeqShiftDir;
  logic [DATA_W-1:0] dataInSeqA;
  logic [DATA_W-1:0] dataInSeqB;
  logic [DATA_W-1:0] dataInSeqC;

  // ALU drive and return
  logic [DATA_W-1:0] dataOutAluA;
  logic [DATA_W-1:0] dataOutAluB;
  logic [OP_W-1:0]   controlOutAluOp;
  logic [SDIR_W-1:0] controlOutAluShiftDir;
  logic [CNT_W-1:0]  controlOutAluCycleCnt;
  logic [DATA_W-1:0] dataInAluResult;
  logic              controlInAluZ;
  logic              controlInAluC;
  logic              controlInAluV;
  logic              controlInAluN;

  // result side
  logic              controlOutSeqValid;
  logic              controlInSeqOutReady;
  logic [DATA_W-1:0] dataOutSeqResult;
  logic [FLAG_W-1:0] controlOutSeqFlags;
  logic              controlOutSeqBusy;

  modport master (
    output controlInSeqValid, controlInSeqOp, controlInSeqShiftDir,
           dataInSeqA, dataInSeqB, dataInSeqC,
           dataInAluResult, controlInAluZ, controlInAluC, controlInAluV, controlInAluN,
           controlInSeqOutReady,
    input  controlOutSeqReady, dataOutAluA, dataOutAluB, controlOutAluOp,
           controlOutAluShiftDir, controlOutAluCycleCnt,
           controlOutSeqValid, dataOutSeqResult, controlOutSeqFlags, controlOutSeqBusy
  );

  modport slave (
    input  controlInSeqValid, controlInSeqOp, controlInSeqShiftDir,
           dataInSeqA, dataInSeqB, dataInSeqC,
           dataInAluResult, controlInAluZ, controlInAluC, controlInAluV, controlInAluN,
           controlInSeqOutReady,
    output controlOutSeqReady, dataOutAluA, dataOutAluB, controlOutAluOp,
           controlOutAluShiftDir, controlOutAluCycleCnt,
           controlOutSeqValid, dataOutSeqResult, controlOutSeqFlags, controlOutSeqBusy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue controller feeding the execute-stage ALU; holds the registered result until accepted.
// Macro ALU_SEQ_ACCUM_EN enables the four-pass ACCUMBYTES sequence (else it issues as one pass).
module alu_op_sequencer #(
  parameter int unsigned DATA_W     = 40,
  parameter int unsigned ACC_PASSES = 4
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  localparam int unsigned OP_W   = 5;
  localparam int unsigned SDIR_W = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned FLAG_W = 4;

  // The ACC state chain is written out for exactly four passes.
  if (ACC_PASSES != 4) begin : g_acc_passes_check
    $error("alu_op_sequencer supports ACC_PASSES == 4 only");
  end

`ifdef ALU_SEQ_ACCUM_EN
  localparam logic [OP_W-1:0]  OP_ACCUMBYTES = 5'h10;
  localparam logic [CNT_W-1:0] LAST_PASS     = CNT_W'(ACC_PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_ACC0, S_ACC1, S_ACC2, S_ACC3, S_DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_DONE
  } state_e;
`endif

  state_e state_q, state_d;

  // ALU drive registers; alu_a also serves as the ACCUMBYTES accumulator between passes
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [SDIR_W-1:0] alu_sdir_q, alu_sdir_d;
  logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d;
`ifdef ALU_SEQ_ACCUM_EN
  logic [DATA_W-1:0] c_q, c_d;
`endif

  logic [DATA_W-1:0] res_q, res_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [FLAG_W-1:0] alu_flags;
  assign alu_flags = {bus.controlInAluN, bus.controlInAluZ, bus.controlInAluC, bus.controlInAluV};

  // Next-state, drive and result logic
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    alu_sdir_d = alu_sdir_q;
    alu_cnt_d  = alu_cnt_q;
`ifdef ALU_SEQ_ACCUM_EN
    c_d        = c_q;
`endif
    res_d      = res_q;
    flags_d    = flags_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.controlInSeqValid) begin
          alu_a_d    = bus.dataInSeqA;
          alu_b_d    = bus.dataInSeqB;
          alu_op_d   = bus.controlInSeqOp;
          alu_sdir_d = bus.controlInSeqShiftDir;
          alu_cnt_d  = '0;
`ifdef ALU_SEQ_ACCUM_EN
          c_d        = bus.dataInSeqC;
          state_d    = (bus.controlInSeqOp == OP_ACCUMBYTES) ? S_ACC0 : S_EXEC;
`else
          state_d    = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        res_d   = bus.dataInAluResult;
        flags_d = alu_flags;
        state_d = S_DONE;
      end
`ifdef ALU_SEQ_ACCUM_EN
      S_ACC0: begin
        alu_a_d   = bus.dataInAluResult;
        alu_b_d   = c_q;
        alu_cnt_d = 3'd1;
        state_d   = S_ACC1;
      end
      S_ACC1: begin
        alu_a_d   = bus.dataInAluResult;
        alu_b_d   = '0;
        alu_cnt_d = 3'd2;
        state_d   = S_ACC2;
      end
      S_ACC2: begin
        alu_a_d   = bus.dataInAluResult;
        alu_b_d   = '0;
        alu_cnt_d = LAST_PASS;
        state_d   = S_ACC3;
      end
      S_ACC3: begin
        res_d   = bus.dataInAluResult;
        flags_d = alu_flags;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (bus.controlInSeqOutReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      alu_sdir_q <= '0;
      alu_cnt_q  <= '0;
`ifdef ALU_SEQ_ACCUM_EN
      c_q        <= '0;
`endif
      res_q      <= '0;
      flags_q    <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      alu_sdir_q <= alu_sdir_d;
      alu_cnt_q  <= alu_cnt_d;
`ifdef ALU_SEQ_ACCUM_EN
      c_q        <= c_d;
`endif
      res_q      <= res_d;
      flags_q    <= flags_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.controlOutSeqReady    = ready_q;
  assign bus.controlOutSeqBusy     = busy_q;
  assign bus.controlOutSeqValid    = valid_q;
  assign bus.dataOutSeqResult      = res_q;
  assign bus.controlOutSeqFlags    = flags_q;
  assign bus.dataOutAluA           = alu_a_q;
  assign bus.dataOutAluB           = alu_b_q;
  assign bus.controlOutAluOp       = alu_op_q;
  assign bus.controlOutAluShiftDir = alu_sdir_q;
  assign bus.controlOutAluCycleCnt = alu_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU closes the loop, and a per-operation
// reference model predicts result, flags and latency for directed and random requests.
module tb_alu_op_sequencer;
  localparam int unsigned DATA_W = 40;
  localparam logic [4:0] OP_ADD        = 5'h00;
  localparam logic [4:0] OP_SUB        = 5'h01;
  localparam logic [4:0] OP_MOV        = 5'h02;
  localparam logic [4:0] OP_ACCUMBYTES = 5'h10;
  localparam logic [4:0] OP_UNDEF      = 5'h1F;
`ifdef ALU_SEQ_ACCUM_EN
  localparam bit ACCUM_EN = 1'b1;
`else
  localparam bit ACCUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [2:0] cnts[$];

  alu_op_sequencer_if #(.DATA_W(DATA_W)) bus ();

  alu_op_sequencer #(.DATA_W(DATA_W), .ACC_PASSES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: returns {N,Z,C,V,result}
  function automatic logic [43:0] alu_eval(input logic [4:0] op, input logic [1:0] dir,
                                           input logic [2:0] cnt, input logic [39:0] a,
                                           input logic [39:0] b);
    logic [40:0] w;
    logic [39:0] r;
    logic c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b}; r = w[39:0]; c = w[40];
        v = (a[39] == b[39]) && (r[39] != a[39]);
      end
      OP_SUB: begin
        w = {1'b0, a} - {1'b0, b}; r = w[39:0]; c = ~w[40];
        v = (a[39] != b[39]) && (r[39] != a[39]);
      end
      OP_MOV: begin
        case (dir)
          2'd0:    r = a;
          2'd1:    r = a << 1;
          2'd2:    r = a >> 1;
          default: r = {a[0], a[39:1]};
        endcase
      end
      OP_ACCUMBYTES: begin
        case (cnt)
          3'd0: r = (40'(a[7:0]) + 40'(b[7:0]))
                  + ((40'(a[15:8]) + 40'(b[15:8])) << 9)
                  + ((40'(a[23:16]) + 40'(b[23:16])) << 17);
          3'd1: r = 40'(a[8:0]) + 40'(a[16:9]) + 40'(a[25:17]) + 40'(b[8:0]) + 40'(b[17:9]);
          default: begin w = {1'b0, a} + {1'b0, b}; r = w[39:0]; c = w[40]; end
        endcase
      end
      default: r = a ^ b;
    endcase
    return {r[39], (r == 40'd0), c, v, r};
  endfunction

  // Reference: what the consumer should see for one request
  function automatic logic [43:0] ref_op(input logic [4:0] op, input logic [1:0] dir,
                                         input logic [39:0] a, input logic [39:0] b,
                                         input logic [39:0] c);
    logic [43:0] p;
    p = alu_eval(op, dir, 3'd0, a, b);
    if (ACCUM_EN && op == OP_ACCUMBYTES) begin
      p = alu_eval(op, dir, 3'd1, p[39:0], c);
      p = alu_eval(op, dir, 3'd2, p[39:0], 40'd0);
      p = alu_eval(op, dir, 3'd3, p[39:0], 40'd0);
    end
    return p;
  endfunction

  function automatic int exp_lat(input logic [4:0] op);
    return (ACCUM_EN && op == OP_ACCUMBYTES) ? 5 : 2;
  endfunction

  logic [43:0] alu_out;
  always_comb alu_out = alu_eval(bus.controlOutAluOp, bus.controlOutAluShiftDir,
                                 bus.controlOutAluCycleCnt, bus.dataOutAluA, bus.dataOutAluB);
  assign bus.dataInAluResult = alu_out[39:0];
  assign bus.controlInAluN   = alu_out[43];
  assign bus.controlInAluZ   = alu_out[42];
  assign bus.controlInAluC   = alu_out[41];
  assign bus.controlInAluV   = alu_out[40];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one request from IDLE and wait (bounded) for the result; lat=0 means timeout
  task automatic run_op(input logic [4:0] op, input logic [1:0] dir, input logic [39:0] a,
                        input logic [39:0] b, input logic [39:0] c,
                        output logic [39:0] res, output logic [3:0] flg, output int lat);
    @(negedge clk);
    bus.controlInSeqValid    = 1'b1;
    bus.controlInSeqOp       = op;
    bus.controlInSeqShiftDir = dir;
    bus.dataInSeqA           = a;
    bus.dataInSeqB           = b;
    bus.dataInSeqC           = c;
    lat = 0;
    cnts.delete();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.controlInSeqValid = 1'b0;
      if (bus.controlOutSeqValid === 1'b1) begin
        lat = k;
        break;
      end
      cnts.push_back(bus.controlOutAluCycleCnt);
      if (k == 1) begin
        chk("busy_after_accept", 64'(bus.controlOutSeqBusy), 64'd1);
        chk("ready_after_accept", 64'(bus.controlOutSeqReady), 64'd0);
      end
    end
    res = bus.dataOutSeqResult;
    flg = bus.controlOutSeqFlags;
  endtask

  initial begin
    logic [39:0] res, ra, rb, rc;
    logic [3:0]  flg;
    logic [4:0]  rop;
    logic [1:0]  rdir;
    logic [43:0] e;
    int          lat;

    bus.controlInSeqValid    = 1'b0;
    bus.controlInSeqOp       = '0;
    bus.controlInSeqShiftDir = '0;
    bus.dataInSeqA           = '0;
    bus.dataInSeqB           = '0;
    bus.dataInSeqC           = '0;
    bus.controlInSeqOutReady = 1'b1;

    // reset state
    #12;
    chk("rst_ready", 64'(bus.controlOutSeqReady), 64'd1);
    chk("rst_valid", 64'(bus.controlOutSeqValid), 64'd0);
    chk("rst_busy", 64'(bus.controlOutSeqBusy), 64'd0);
    chk("rst_flags", 64'(bus.controlOutSeqFlags), 64'd0);
    chk("rst_result", 64'(bus.dataOutSeqResult), 64'd0);
    chk("rst_alu_a", 64'(bus.dataOutAluA), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD 5+7
    run_op(OP_ADD, 2'd0, 40'd5, 40'd7, 40'd0, res, flg, lat);
    chk("add_lat", 64'(lat), 64'd2);
    chk("add_res", 64'(res), 64'h0C);
    chk("add_flags", 64'(flg), 64'd0);
    chk("add_cnt", 64'(bus.controlOutAluCycleCnt), 64'd0);

    // SUB 3-5
    run_op(OP_SUB, 2'd0, 40'd3, 40'd5, 40'd0, res, flg, lat);
    chk("sub_lat", 64'(lat), 64'd2);
    chk("sub_res", 64'(res), 64'hFFFFFFFFFE);
    chk("sub_n", 64'(flg[3]), 64'd1);
    chk("sub_z", 64'(flg[2]), 64'd0);
    e = ref_op(OP_SUB, 2'd0, 40'd3, 40'd5, 40'd0);
    chk("sub_flags", 64'(flg), 64'(e[43:40]));

    // ACCUMBYTES
    run_op(OP_ACCUMBYTES, 2'd0, 40'h0000030201, 40'h0000060504, 40'd0, res, flg, lat);
    chk("acc_lat", 64'(lat), 64'(exp_lat(OP_ACCUMBYTES)));
    chk("acc_res", 64'(res), ACCUM_EN ? 64'h15 : 64'h120E05);
    chk("acc_flags", 64'(flg), 64'd0);
    chk("acc_cnt_len", 64'(cnts.size()), ACCUM_EN ? 64'd4 : 64'd1);
    for (int i = 0; i < cnts.size(); i++) chk($sformatf("acc_cnt%0d", i), 64'(cnts[i]), 64'(i));
    @(negedge clk);
    chk("acc_back_idle", 64'(bus.controlOutSeqReady), 64'd1);

    // backpressure with a competing request
    bus.controlInSeqOutReady = 1'b0;
    run_op(OP_ADD, 2'd0, 40'd1, 40'd1, 40'd0, res, flg, lat);
    chk("bp_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 3) begin
        bus.controlInSeqValid = 1'b1;
        bus.controlInSeqOp    = OP_SUB;
        bus.dataInSeqA        = 40'd9;
        bus.dataInSeqB        = 40'd9;
      end else begin
        bus.controlInSeqValid    = 1'b0;
        bus.controlInSeqOutReady = 1'b1;
      end
      chk("bp_valid", 64'(bus.controlOutSeqValid), 64'd1);
      chk("bp_res", 64'(bus.dataOutSeqResult), 64'd2);
      chk("bp_ready", 64'(bus.controlOutSeqReady), 64'd0);
    end
    @(negedge clk);
    chk("bp_idle_ready", 64'(bus.controlOutSeqReady), 64'd1);
    chk("bp_idle_valid", 64'(bus.controlOutSeqValid), 64'd0);
    @(negedge clk);
    chk("bp_competing_ignored", 64'(bus.controlOutSeqBusy), 64'd0);

    // reset during the third ACCUMBYTES pass
    bus.controlInSeqOutReady = 1'b0;
    bus.controlInSeqValid    = 1'b1;
    bus.controlInSeqOp       = OP_ACCUMBYTES;
    bus.dataInSeqA           = 40'h0000030201;
    bus.dataInSeqB           = 40'h0000060504;
    bus.dataInSeqC           = 40'd0;
    @(negedge clk);
    bus.controlInSeqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 64'(bus.controlOutSeqBusy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.controlOutSeqValid), 64'd0);
    chk("mid_rst_busy", 64'(bus.controlOutSeqBusy), 64'd0);
    chk("mid_rst_ready", 64'(bus.controlOutSeqReady), 64'd1);
    chk("mid_rst_flags", 64'(bus.controlOutSeqFlags), 64'd0);
    chk("mid_rst_cnt", 64'(bus.controlOutAluCycleCnt), 64'd0);
    #1;
    rst = 1'b0;
    bus.controlInSeqOutReady = 1'b1;
    run_op(OP_ADD, 2'd0, 40'd2, 40'd2, 40'd0, res, flg, lat);
    chk("post_rst_lat", 64'(lat), 64'd2);
    chk("post_rst_res", 64'(res), 64'd4);

    // randomized requests against the reference model
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0:       rop = OP_ADD;
        1:       rop = OP_SUB;
        2:       rop = OP_MOV;
        3:       rop = OP_ACCUMBYTES;
        default: rop = OP_UNDEF;
      endcase
      rdir = 2'($urandom);
      ra   = {8'($urandom), 32'($urandom)};
      rb   = {8'($urandom), 32'($urandom)};
      rc   = {22'd0, 18'($urandom)};
      e    = ref_op(rop, rdir, ra, rb, rc);
      run_op(rop, rdir, ra, rb, rc, res, flg, lat);
      chk($sformatf("rnd%0d_op%0h_lat", i, rop), 64'(lat), 64'(exp_lat(rop)));
      chk($sformatf("rnd%0d_op%0h_res", i, rop), 64'(res), 64'(e[39:0]));
      chk($sformatf("rnd%0d_op%0h_flags", i, rop), 64'(flg), 64'(e[43:40]));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
